cmd_rx_deser: RTL

- Loopback/monitor stage directly downstream of the command sequencer. Runs in the command clock domain.
- Samples the serialized command bit stream (posedge output mode, one bit per clock) while the frame-valid qualifier is high.
- Packs bits MSB-first into bytes and marks the final byte of each frame with LAST plus a valid-bit count.
- Buffers bytes in a show-ahead FIFO with a valid/ready output handshake, for readback or comparison against the programmed command memory.

---
 rtl/cmd_rx_deser.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/cmd_rx_deser.sv
// cmd_rx_deser: captures the serialized command stream from the sequencer.
// Bits are packed MSB-first into bytes. The final byte of each frame is tagged
// with LAST and a count of its valid bits. Bytes are buffered in a show-ahead
// FIFO that the consumer drains through a valid/ready handshake.
module cmd_rx_deser #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ENABLE,
  input  logic                 SER_DATA,
  input  logic                 SER_VALID,
  output logic [7:0]           BYTE_DATA,
  output logic                 BYTE_LAST,
  output logic [2:0]           BYTE_NBITS,
  output logic                 BYTE_VALID,
  input  logic                 BYTE_READY,
  output logic [CNT_WIDTH-1:0] FRAME_CNT,
  output logic [CNT_WIDTH-1:0] LAST_FRAME_BITS,
  output logic                 OVERFLOW,
  input  logic                 CLEAR_OVF
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]          PTR_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  typedef enum logic {IDLE, RECV} state_t;

  // Capture state
  state_t               state_q, state_d;
  logic                 blocked_q, blocked_d;
  logic [7:0]           shift_q, shift_d;
  logic [2:0]           idx_q, idx_d;
  logic                 pend_q, pend_d;
  logic [7:0]           pend_byte_q, pend_byte_d;
  logic [CNT_WIDTH-1:0] bits_q, bits_d;
  logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_WIDTH-1:0] last_bits_q, last_bits_d;
  logic                 take_bit;

  // FIFO entry: {last, nbits[2:0], data[7:0]}
  logic                 push;
  logic [11:0]          push_word;

  // FIFO state
  logic [11:0]          mem_q [FIFO_DEPTH];
  logic [AW:0]          wr_ptr_q, rd_ptr_q;
  logic                 ovf_q;
  logic                 empty, full, pop, push_ok, drop;
  logic [11:0]          head;

  // Frame FSM and bit packer next-state. A completed byte waits in the pending
  // register and is pushed only when the next bit arrives. The frame end can
  // then always issue exactly one push without colliding with a byte push.
  always_comb begin
    state_d     = state_q;
    blocked_d   = blocked_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    pend_d      = pend_q;
    pend_byte_d = pend_byte_q;
    bits_d      = bits_q;
    frame_cnt_d = frame_cnt_q;
    last_bits_d = last_bits_q;
    take_bit    = 1'b0;
    push        = 1'b0;
    push_word   = '0;

    unique case (state_q)
      IDLE: begin
        if (!SER_VALID) begin
          blocked_d = 1'b0;
        end else if (!blocked_q) begin
          if (ENABLE) begin
            state_d  = RECV;
            take_bit = 1'b1;
          end else begin
            blocked_d = 1'b1;
          end
        end
      end
      RECV: begin
        if (SER_VALID) begin
          take_bit = 1'b1;
        end else begin
          state_d = IDLE;
          push    = 1'b1;
          if (idx_q != 3'd0) begin
            // Left-align the k partial bits: shift by 8-k, which is -k mod 8
            push_word = {1'b1, idx_q, shift_q << (3'd0 - idx_q)};
          end else begin
            push_word = {1'b1, 3'd0, pend_byte_q};
          end
          frame_cnt_d = frame_cnt_q + CNT_ONE;
          last_bits_d = bits_q;
          shift_d     = '0;
          idx_d       = '0;
          pend_d      = 1'b0;
          pend_byte_d = '0;
          bits_d      = '0;
        end
      end
    endcase

    if (take_bit) begin
      shift_d = {shift_q[6:0], SER_DATA};
      idx_d   = idx_q + 3'd1;
      if (bits_q != '1) begin
        bits_d = bits_q + CNT_ONE;
      end
      if (pend_q) begin
        push      = 1'b1;
        push_word = {1'b0, 3'd0, pend_byte_q};
      end
      if (idx_q == 3'd7) begin
        pend_d      = 1'b1;
        pend_byte_d = {shift_q[6:0], SER_DATA};
      end else begin
        pend_d = 1'b0;
      end
    end
  end

  // Capture registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      blocked_q   <= 1'b0;
      shift_q     <= '0;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      pend_byte_q <= '0;
      bits_q      <= '0;
      frame_cnt_q <= '0;
      last_bits_q <= '0;
    end else begin
      state_q     <= state_d;
      blocked_q   <= blocked_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_byte_q <= pend_byte_d;
      bits_q      <= bits_d;
      frame_cnt_q <= frame_cnt_d;
      last_bits_q <= last_bits_d;
    end
  end

  // FIFO status. A pop in the same cycle frees a slot, so a push to a full FIFO still succeeds.
  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop     = !empty && BYTE_READY;
    push_ok = push && (!full || pop);
    drop    = push && full && !pop;
    head    = mem_q[rd_ptr_q[AW-1:0]];
  end

  // FIFO storage. Contents are not reset; the outputs are masked while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_word;
    end
  end

  // FIFO pointers and sticky overflow (a drop takes priority over a clear)
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (CLEAR_OVF) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // Output mapping of the show-ahead head entry
  always_comb begin
    BYTE_VALID = !empty;
    BYTE_DATA  = empty ? 8'd0 : head[7:0];
    BYTE_NBITS = empty ? 3'd0 : head[10:8];
    BYTE_LAST  = empty ? 1'b0 : head[11];
  end

  assign FRAME_CNT       = frame_cnt_q;
  assign LAST_FRAME_BITS = last_bits_q;
  assign OVERFLOW        = ovf_q;

endmodule
